// File: rtl/video_crop.sv
// video_crop: passes a programmable rectangle of a do/de/hs/vs video stream and
// measures the incoming line size and frame height.
module video_crop #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_WIDTH-1:0]  crop_x,
    input  logic [CNT_WIDTH-1:0]  crop_y,
    input  logic [CNT_WIDTH-1:0]  crop_w,
    input  logic [CNT_WIDTH-1:0]  crop_h,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [CNT_WIDTH-1:0]  line_size_o,
    output logic [CNT_WIDTH-1:0]  frame_lines_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    logic [CNT_WIDTH-1:0] x_cnt, y_cnt, sx, sy, sw, sh;
    logic [CNT_WIDTH:0]   x_end, y_end;
    logic                 hs_q, sync, in_x, in_y, hs_rise, vs_rise, de_n;
    // window ends are one bit wider so x+w never wraps
    assign x_end   = {1'b0, sx} + {1'b0, sw};
    assign y_end   = {1'b0, sy} + {1'b0, sh};
    assign in_x    = (x_cnt >= sx) && ({1'b0, x_cnt} < x_end);
    assign in_y    = (y_cnt >= sy) && ({1'b0, y_cnt} < y_end);
    assign hs_rise = hs_i && !hs_q;
    assign vs_rise = vs_i && !vs_o;
    assign de_n    = sync && de_i && !hs_i && in_x && in_y;
    always_ff @(posedge clk) begin
        if (rst) begin
            do_o          <= '0;
            de_o          <= 1'b0;
            hs_o          <= 1'b1;
            vs_o          <= 1'b1;
            line_size_o   <= '0;
            frame_lines_o <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            sx            <= '0;
            sy            <= '0;
            sw            <= '0;
            sh            <= '0;
            hs_q          <= 1'b1;
            sync          <= 1'b0;
        end else begin
            vs_o <= vs_i;
            hs_q <= hs_i;
            sync <= sync || vs_i;
            if (vs_i) begin
                sx <= crop_x;
                sy <= crop_y;
                sw <= crop_w;
                sh <= crop_h;
            end
            x_cnt <= hs_i ? '0 : (de_i && x_cnt != CNT_MAX) ? x_cnt + 1'b1 : x_cnt;
            y_cnt <= vs_i ? '0 : (hs_rise && y_cnt != CNT_MAX) ? y_cnt + 1'b1 : y_cnt;
            de_o  <= de_n;
            if (de_n)
                do_o <= di_i;
            hs_o <= (sync && in_y) ? hs_i : 1'b1;
            if (hs_rise)
                line_size_o <= x_cnt;
            // a line ending together with the frame still counts
            if (vs_rise)
                frame_lines_o <= (hs_rise && y_cnt != CNT_MAX) ? y_cnt + 1'b1 : y_cnt;
        end
    end
endmodule

// File: tb/tb_video_crop.sv
// tb_video_crop: random frames through video_crop, checked against a
// window-geometry model of which pixels and lines should survive.
module tb_video_crop;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] crop_x, crop_y, crop_w, crop_h;
    logic [7:0]  di_i, do_o;
    logic        de_i, hs_i, vs_i, de_o, hs_o, vs_o;
    logic [11:0] line_size_o, frame_lines_o;

    video_crop #(.DATA_WIDTH(8), .CNT_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
        .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
        .line_size_o(line_size_o), .frame_lines_o(frame_lines_o)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_err = 0, hs_falls = 0;
    logic [7:0] got[$], exp_q[$];
    logic [7:0] pix[0:63][0:63];
    logic       vs_last, rst_last, hs_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got_v, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        vs_last  <= vs_i;
        rst_last <= rst;
    end

    always @(negedge clk) begin
        if (de_o)
            got.push_back(do_o);
        if (hs_prev && !hs_o)
            hs_falls++;
        hs_prev = hs_o;
        if (rst_last === 1'b0)
            check("vs_o_delay", vs_o, vs_last);
    end

    task automatic check_reset();
        @(negedge clk);
        check("rst_do", do_o, 0);
        check("rst_de", de_o, 0);
        check("rst_hs", hs_o, 1);
        check("rst_vs", vs_o, 1);
        check("rst_line_size", line_size_o, 0);
        check("rst_frame_lines", frame_lines_o, 0);
    endtask

    task automatic run_frame(input int w, h, cx, cy, cw, ch, chg_line, new_cx, rst_line,
                             input bit same_edge, pat);
        int n_lines, g;
        bit rst_seen;
        rst_seen = 0;
        n_lines  = 0;
        exp_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                pix[y][x] = pat ? 8'((x + y * w) & 255) : 8'($urandom);
        // geometry model: a pixel survives iff it lies in the rectangle
        for (int y = 0; y < h; y++)
            if (y >= cy && y < cy + ch) begin
                n_lines++;
                for (int x = 0; x < w; x++)
                    if (x >= cx && x < cx + cw)
                        exp_q.push_back(pix[y][x]);
            end
        crop_x = 12'(cx);
        crop_y = 12'(cy);
        crop_w = 12'(cw);
        crop_h = 12'(ch);
        vs_i = 1; hs_i = 1; de_i = 0;
        repeat (3) tick();
        vs_i = 0;
        tick();
        for (int y = 0; y < h; y++) begin
            hs_i = 0;
            for (int x = 0; x < w; x++) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    de_i = 0;
                    tick();
                end
                if (y == chg_line && x == 0)
                    crop_x = 12'(new_cx);
                de_i = 1;
                di_i = pix[y][x];
                tick();
                if (y == rst_line && x == w / 2) begin
                    rst = 1; de_i = 0;
                    tick();
                    rst = 0;
                    check_reset();
                    got.delete();
                    rst_seen = 1;
                end
            end
            hs_i = 1;
            de_i = 1'($urandom);
            di_i = 8'($urandom);
            if (y == h - 1 && same_edge)
                vs_i = 1;
            tick();
            de_i = 1'($urandom);
            tick();
            de_i = 0;
        end
        vs_i = 1;
        repeat (4) tick();
        @(negedge clk);
        if (rst_seen) begin
            check("post_rst_npix", got.size(), 0);
        end else begin
            check("npix", got.size(), exp_q.size());
            for (int i = 0; i < got.size() && i < exp_q.size(); i++)
                check("pix", got[i], exp_q[i]);
            check("out_lines", hs_falls, n_lines);
        end
        check("line_size", line_size_o, w);
        check("frame_lines", frame_lines_o, rst_seen ? h - rst_line : h);
    endtask

    task automatic clear_frame();
        got.delete();
        hs_falls = 0;
    endtask

    initial begin
        int w, h, cx, cy, cw, ch;
        rst = 1; vs_i = 1; hs_i = 1; de_i = 0; di_i = 0;
        crop_x = 0; crop_y = 0; crop_w = 0; crop_h = 0;
        tick();
        check_reset();
        tick();
        rst = 0;
        run_frame(25, 25, 2, 3, 10, 5, -1, 0, -1, 0, 1);
        if (got.size() > 0) begin
            check("first_pix", got[0], 77);
            check("last_pix", got[got.size() - 1], 186);
        end
        clear_frame();
        run_frame(25, 25, 20, 0, 10, 25, -1, 0, -1, 0, 0); clear_frame();
        run_frame(25, 25, 3, 0, 0, 25, -1, 0, -1, 1, 0);   clear_frame();
        run_frame(25, 25, 3, 2, 5, 0, -1, 0, -1, 0, 0);    clear_frame();
        run_frame(25, 25, 2, 0, 10, 25, 10, 5, -1, 0, 0);  clear_frame();
        run_frame(25, 25, 5, 0, 10, 25, -1, 5, -1, 0, 0);  clear_frame();
        run_frame(25, 25, 2, 3, 10, 5, -1, 0, 12, 0, 0);   clear_frame();
        run_frame(25, 25, 2, 3, 10, 5, -1, 0, -1, 0, 0);   clear_frame();
        run_frame(13, 13, 0, 0, 4095, 4095, -1, 0, -1, 1, 0); clear_frame();
        run_frame(13, 13, 4095, 4095, 4095, 4095, -1, 0, -1, 0, 0); clear_frame();
        for (int f = 0; f < 8; f++) begin
            w  = $urandom_range(1, 30);
            h  = $urandom_range(1, 30);
            cx = ($urandom_range(0, 4) == 0) ? 4095 : $urandom_range(0, 35);
            cy = $urandom_range(0, 35);
            cw = ($urandom_range(0, 4) == 0) ? 4095 : $urandom_range(0, 35);
            ch = ($urandom_range(0, 4) == 0) ? 4095 : $urandom_range(0, 35);
            run_frame(w, h, cx, cy, cw, ch, -1, 0, -1, 1'($urandom), 0);
            clear_frame();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
